// File: rtl/auth_pkg.sv
// -----------------------------------------------------------------------------
// auth_pkg
// Shared definitions for the rider-auth command transmitter:
//   CMD_GO / CMD_STOP : the two command bytes carried on the auth UART
//   tx_state_t        : transmitter state encoding, used by the top-level FSM
//                       and by the UART core for its own bit phase
// -----------------------------------------------------------------------------
package auth_pkg;

   localparam logic [7:0] CMD_GO   = 8'h67;  // 'g' power-up / go
   localparam logic [7:0] CMD_STOP = 8'h73;  // 's' stop

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4,
      GAP   = 3'd5
   } tx_state_t;

endpackage : auth_pkg

// File: rtl/auth_cmd_tx_uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
// 8N1 serializer: start bit, 8 data bits LSB first, stop bit, each bit lasting
// exactly BAUD_DIV clk cycles. Owns the baud counter, bit counter and shift
// register. A frame starts when load is high while the core is idle.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   load       in   start a frame with data (ignored while a frame is running)
//   data[7:0]  in   byte to send, captured on load
//   tx         out  serial line, idle high (registered)
//   frame_done out  high for the last clk cycle of the stop bit (registered)
//   bit_end    out  current cycle is the last one of a start or data bit
//   last_data  out  bit counter is on data bit 7
// -----------------------------------------------------------------------------
module uart_tx_core
   import auth_pkg::*;
#(
   parameter int BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       frame_done,
   output logic       bit_end,
   output logic       last_data
);

   localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);

   tx_state_t   phase_reg;
   logic [11:0] baud_cnt_reg;
   logic [2:0]  bit_cnt_reg;
   logic [7:0]  shift_reg;
   logic        tx_reg;
   logic        frame_done_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_reg      <= IDLE;
         baud_cnt_reg   <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         tx_reg         <= 1'b1;
         frame_done_reg <= 1'b0;
      end else begin
         frame_done_reg <= 1'b0;
         case (phase_reg)
            IDLE: begin
               tx_reg <= 1'b1;
               if (load) begin
                  phase_reg    <= START;
                  tx_reg       <= 1'b0;
                  baud_cnt_reg <= BAUD_RELOAD;
                  shift_reg    <= data;
               end
            end
            START: begin
               if (baud_cnt_reg == '0) begin
                  phase_reg    <= DATA;
                  tx_reg       <= shift_reg[0];
                  shift_reg    <= {1'b0, shift_reg[7:1]};
                  bit_cnt_reg  <= '0;
                  baud_cnt_reg <= BAUD_RELOAD;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg - 12'd1;
               end
            end
            DATA: begin
               if (baud_cnt_reg == '0) begin
                  baud_cnt_reg <= BAUD_RELOAD;
                  if (bit_cnt_reg == 3'd7) begin
                     phase_reg <= STOP;
                     tx_reg    <= 1'b1;
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     tx_reg      <= shift_reg[0];
                     shift_reg   <= {1'b0, shift_reg[7:1]};
                  end
               end else begin
                  baud_cnt_reg <= baud_cnt_reg - 12'd1;
               end
            end
            STOP: begin
               // Raise frame_done one cycle early so that, being a register,
               // it is high exactly during the final stop-bit cycle.
               if (baud_cnt_reg == 12'd1) begin
                  frame_done_reg <= 1'b1;
               end
               if (baud_cnt_reg == '0) begin
                  phase_reg <= IDLE;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg - 12'd1;
               end
            end
            default: begin
               phase_reg <= IDLE;
               tx_reg    <= 1'b1;
            end
         endcase
      end
   end

   assign tx         = tx_reg;
   assign frame_done = frame_done_reg;
   assign bit_end    = (phase_reg != IDLE) && (baud_cnt_reg == '0);
   assign last_data  = (bit_cnt_reg == 3'd7);

endmodule : uart_tx_core

// File: rtl/auth_cmd_tx.sv
// -----------------------------------------------------------------------------
// auth_cmd_tx
// Host-side rider-auth command transmitter. Turns one-cycle go/stop requests
// into 8N1 UART frames (0x67 go, 0x73 stop) with GAP_BITS idle bit-times after
// every frame. One pending request is held while a frame is in flight; the
// newest request wins, except that a pending stop is never replaced by a go.
//
// Optional feature (macro AUTH_HEARTBEAT_EN): while go_active is set and the
// transmitter is idle with nothing pending, 0x67 is re-queued every HB_PERIOD
// clk cycles, counted from the last completed frame.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   go_req     in   one-cycle request to send 0x67
//   stop_req   in   one-cycle request to send 0x73 (beats go_req)
//   TX         out  UART serial out, idle high
//   busy       out  high from frame load until the end of the gap
//   cmd_sent   out  one-cycle pulse on the last stop-bit cycle
//   last_cmd   out  byte of the most recently completed frame
//   go_active  out  1 after a go frame completes, 0 after a stop frame
// -----------------------------------------------------------------------------
module auth_cmd_tx
   import auth_pkg::*;
#(
   parameter int BAUD_DIV  = 2604,
   parameter int GAP_BITS  = 2,
   parameter int HB_PERIOD = 2**22
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       go_req,
   input  logic       stop_req,
   output logic       TX,
   output logic       busy,
   output logic       cmd_sent,
   output logic [7:0] last_cmd,
   output logic       go_active
);

   localparam int GAP_CYC = GAP_BITS * BAUD_DIV;
   localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

   tx_state_t        state_reg;
   logic             slot_valid_reg;
   logic [7:0]       slot_byte_reg;
   logic [7:0]       cur_byte_reg;
   logic [GAP_W-1:0] gap_cnt_reg;
   logic             busy_reg;
   logic [7:0]       last_cmd_reg;
   logic             go_active_reg;

   logic core_tx;
   logic frame_done;
   logic bit_end;
   logic last_data;
   logic hb_fire;

   // ---------------------------------------------------------------- requests
   logic       req_any;
   logic [7:0] req_byte;
   logic       slot_keep;

   assign req_any  = go_req | stop_req | hb_fire;
   assign req_byte = stop_req ? CMD_STOP : CMD_GO;
   // A pending stop survives a go-only request. During LOAD the slot is being
   // emptied into the core, so anything arriving then simply refills it.
   assign slot_keep = slot_valid_reg && (slot_byte_reg == CMD_STOP) && !stop_req
                      && (state_reg != LOAD);

`ifdef AUTH_HEARTBEAT_EN
   localparam int HB_W = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
   localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_PERIOD - 1);

   logic [HB_W-1:0] hb_cnt_reg;

   assign hb_fire = go_active_reg && (state_reg == IDLE) && !slot_valid_reg
                    && (hb_cnt_reg == HB_LAST);

   // Restarts on every completed frame; saturates at the terminal count until
   // the transmitter is idle and empty so the heartbeat is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hb_cnt_reg <= '0;
      end else if (frame_done || !go_active_reg || hb_fire) begin
         hb_cnt_reg <= '0;
      end else if (hb_cnt_reg != HB_LAST) begin
         hb_cnt_reg <= hb_cnt_reg + 1'b1;
      end
   end
`else
   assign hb_fire = 1'b0;
`endif

   // --------------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         slot_valid_reg <= 1'b0;
         slot_byte_reg  <= 8'h00;
         cur_byte_reg   <= 8'h00;
         gap_cnt_reg    <= '0;
         busy_reg       <= 1'b0;
         last_cmd_reg   <= 8'h00;
         go_active_reg  <= 1'b0;
      end else begin
         if (req_any && !slot_keep) begin
            slot_valid_reg <= 1'b1;
            slot_byte_reg  <= req_byte;
         end else if (state_reg == LOAD) begin
            slot_valid_reg <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               // Looking at the raw request as well as the slot gives the
               // two-cycle request-to-start-bit latency.
               if (slot_valid_reg || req_any) begin
                  state_reg <= LOAD;
                  busy_reg  <= 1'b1;
               end
            end
            LOAD: begin
               cur_byte_reg <= slot_byte_reg;
               state_reg    <= START;
            end
            START: begin
               if (bit_end) begin
                  state_reg <= DATA;
               end
            end
            DATA: begin
               if (bit_end && last_data) begin
                  state_reg <= STOP;
               end
            end
            STOP: begin
               if (frame_done) begin
                  last_cmd_reg  <= cur_byte_reg;
                  go_active_reg <= (cur_byte_reg == CMD_GO);
                  gap_cnt_reg   <= GAP_LOAD;
                  if (GAP_BITS == 0) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end else begin
                     state_reg <= GAP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_reg == '0) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   uart_tx_core #(
      .BAUD_DIV (BAUD_DIV)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (state_reg == LOAD),
      .data       (slot_byte_reg),
      .tx         (core_tx),
      .frame_done (frame_done),
      .bit_end    (bit_end),
      .last_data  (last_data)
   );

   assign TX        = core_tx;
   assign busy      = busy_reg;
   assign cmd_sent  = frame_done;
   assign last_cmd  = last_cmd_reg;
   assign go_active = go_active_reg;

endmodule : auth_cmd_tx

// File: tb/tb_auth_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_auth_cmd_tx
// Directed bench for auth_cmd_tx with BAUD_DIV=16, GAP_BITS=2, HB_PERIOD=2000.
// Inputs change and outputs are sampled on the falling clock edge. A request
// driven in cycle N must give TX low from cycle N+2; a frame is 160 cycles
// with cmd_sent on its last cycle, followed by 32 gap cycles with busy high.
// Compile with +define+AUTH_HEARTBEAT_EN to exercise the heartbeat repeats.
// -----------------------------------------------------------------------------
module tb_auth_cmd_tx;

   localparam int BAUD_DIV  = 16;
   localparam int GAP_BITS  = 2;
   localparam int HB_PERIOD = 2000;
   localparam int FRAME_CYC = 10 * BAUD_DIV;
   localparam int GAP_CYC   = GAP_BITS * BAUD_DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       go_req = 1'b0;
   logic       stop_req = 1'b0;
   logic       tx;
   logic       busy;
   logic       cmd_sent;
   logic [7:0] last_cmd;
   logic       go_active;

   int checks = 0;
   int errors = 0;

   logic [9:0] fb;
   int         bad;
   int         cs_pos;
   logic       busy_after;
   int         act;

   always #5 clk = ~clk;

   auth_cmd_tx #(
      .BAUD_DIV  (BAUD_DIV),
      .GAP_BITS  (GAP_BITS),
      .HB_PERIOD (HB_PERIOD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .go_req    (go_req),
      .stop_req  (stop_req),
      .TX        (tx),
      .busy      (busy),
      .cmd_sent  (cmd_sent),
      .last_cmd  (last_cmd),
      .go_active (go_active)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   // Observes one frame starting at the current cycle (expected start bit).
   // fb holds TX at the middle of each of the 10 bits, bad counts cycles where
   // TX moved inside a bit or busy was low, cs_pos is the frame cycle of the
   // single cmd_sent pulse (-1 none, -2 more than one). Requests can be
   // injected at given frame cycles. Ends on the last frame cycle.
   task automatic capture_frame(input int go_a, input int go_b, input int stop_a,
                                output logic [9:0] fbits, output int nbad, output int cpos);
      logic first;
      int   cs_n;
      first = 1'b1;
      fbits = '0;
      nbad  = 0;
      cpos  = -1;
      cs_n  = 0;
      for (int i = 0; i < FRAME_CYC; i++) begin
         if (i > 0) tick();
         if (i % BAUD_DIV == 0) first = tx;
         if (i % BAUD_DIV == BAUD_DIV / 2) fbits[i / BAUD_DIV] = tx;
         if (tx !== first || busy !== 1'b1) nbad++;
         if (cmd_sent === 1'b1) begin
            cs_n++;
            if (cpos < 0) cpos = i;
         end
         go_req   = (i == go_a) || (i == go_b);
         stop_req = (i == stop_a);
      end
      go_req   = 1'b0;
      stop_req = 1'b0;
      if (cs_n > 1) cpos = -2;
   endtask

   // Walks the 32 gap cycles after cmd_sent, counting cycles that are not
   // busy/idle-high, optionally raising go_req in the last gap cycle, then
   // returns busy of the following cycle.
   task automatic capture_gap(input bit req_last, output int nbad, output logic b_after);
      nbad = 0;
      for (int k = 1; k <= GAP_CYC; k++) begin
         tick();
         if (busy !== 1'b1 || tx !== 1'b1 || cmd_sent !== 1'b0) nbad++;
         if (req_last && k == GAP_CYC) go_req = 1'b1;
      end
      tick();
      b_after = busy;
      go_req  = 1'b0;
   endtask

   // Counts cycles showing any transmit activity over n idle cycles.
   task automatic capture_idle(input int n, output int nact);
      nact = 0;
      repeat (n) begin
         tick();
         if (busy !== 1'b0 || tx !== 1'b1 || cmd_sent !== 1'b0) nact++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (cmd_sent !== 1'b0) begin errors++; $display("FAIL reset_cmd_sent got %b want 0", cmd_sent); end
      checks++; if (last_cmd !== 8'h00) begin errors++; $display("FAIL reset_last_cmd got %h want 00", last_cmd); end
      checks++; if (go_active !== 1'b0) begin errors++; $display("FAIL reset_go_active got %b want 0", go_active); end
      rst_n = 1'b1;
      repeat (4) tick();
      $display("test_reset done");
   endtask

   task automatic test_go();
      go_req = 1'b1;
      tick();
      go_req = 1'b0;
      checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL go_load_cycle got tx=%b busy=%b want tx=1 busy=1", tx, busy); end
      tick();
      capture_frame(-1, -1, -1, fb, bad, cs_pos);
      $display("test_go frame byte %h", fb[8:1]);
      checks++; if (fb !== {1'b1, 8'h67, 1'b0}) begin errors++; $display("FAIL go_frame_bits got %b want %b", fb, {1'b1, 8'h67, 1'b0}); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL go_frame_timing got %0d bad cycles want 0", bad); end
      checks++; if (cs_pos !== FRAME_CYC - 1) begin errors++; $display("FAIL go_cmd_sent got pos %0d want %0d", cs_pos, FRAME_CYC - 1); end
      capture_gap(1'b0, bad, busy_after);
      checks++; if (bad !== 0 || busy_after !== 1'b0) begin errors++; $display("FAIL go_gap got bad=%0d busy_after=%b want 0 0", bad, busy_after); end
      checks++; if (last_cmd !== 8'h67) begin errors++; $display("FAIL go_last_cmd got %h want 67", last_cmd); end
      checks++; if (go_active !== 1'b1) begin errors++; $display("FAIL go_active got %b want 1", go_active); end
      capture_idle(20, act);
      checks++; if (act !== 0) begin errors++; $display("FAIL go_idle got %0d active cycles want 0", act); end
   endtask

   task automatic test_both();
      go_req = 1'b1;
      stop_req = 1'b1;
      tick();
      go_req = 1'b0;
      stop_req = 1'b0;
      tick();
      capture_frame(-1, -1, -1, fb, bad, cs_pos);
      $display("test_both frame byte %h", fb[8:1]);
      checks++; if (fb !== {1'b1, 8'h73, 1'b0}) begin errors++; $display("FAIL both_frame_bits got %b want %b", fb, {1'b1, 8'h73, 1'b0}); end
      checks++; if (cs_pos !== FRAME_CYC - 1) begin errors++; $display("FAIL both_cmd_sent got pos %0d want %0d", cs_pos, FRAME_CYC - 1); end
      capture_gap(1'b0, bad, busy_after);
      checks++; if (last_cmd !== 8'h73 || go_active !== 1'b0) begin errors++; $display("FAIL both_status got last_cmd=%h go_active=%b want 73 0", last_cmd, go_active); end
      capture_idle(40, act);
      checks++; if (act !== 0) begin errors++; $display("FAIL both_single_frame got %0d active cycles want 0", act); end
   endtask

   task automatic test_stop_mid();
      go_req = 1'b1;
      tick();
      go_req = 1'b0;
      tick();
      capture_frame(-1, -1, 70, fb, bad, cs_pos);
      $display("test_stop_mid frame byte %h", fb[8:1]);
      checks++; if (fb !== {1'b1, 8'h67, 1'b0} || bad !== 0) begin errors++; $display("FAIL stopmid_go_frame got %b bad=%0d want %b bad=0", fb, bad, {1'b1, 8'h67, 1'b0}); end
      checks++; if (cs_pos !== FRAME_CYC - 1) begin errors++; $display("FAIL stopmid_cmd_sent1 got pos %0d want %0d", cs_pos, FRAME_CYC - 1); end
      capture_gap(1'b0, bad, busy_after);
      checks++; if (bad !== 0 || busy_after !== 1'b0) begin errors++; $display("FAIL stopmid_gap got bad=%0d busy_after=%b want 0 0", bad, busy_after); end
      checks++; if (go_active !== 1'b1) begin errors++; $display("FAIL stopmid_go_active1 got %b want 1", go_active); end
      tick();
      checks++; if (busy !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL stopmid_load got busy=%b tx=%b want 1 1", busy, tx); end
      tick();
      capture_frame(-1, -1, -1, fb, bad, cs_pos);
      $display("test_stop_mid frame byte %h", fb[8:1]);
      checks++; if (fb !== {1'b1, 8'h73, 1'b0} || bad !== 0) begin errors++; $display("FAIL stopmid_stop_frame got %b bad=%0d want %b bad=0", fb, bad, {1'b1, 8'h73, 1'b0}); end
      checks++; if (cs_pos !== FRAME_CYC - 1) begin errors++; $display("FAIL stopmid_cmd_sent2 got pos %0d want %0d", cs_pos, FRAME_CYC - 1); end
      capture_gap(1'b0, bad, busy_after);
      checks++; if (go_active !== 1'b0) begin errors++; $display("FAIL stopmid_go_active2 got %b want 0", go_active); end
   endtask

   // go, go, stop during one frame: only a single stop frame follows.
   // Then stop, go during one frame: the pending stop must not be replaced.
   task automatic test_queue(input int go_a, input int go_b, input int stop_a, input string nm);
      go_req = 1'b1;
      tick();
      go_req = 1'b0;
      tick();
      capture_frame(go_a, go_b, stop_a, fb, bad, cs_pos);
      checks++; if (fb !== {1'b1, 8'h67, 1'b0} || bad !== 0) begin errors++; $display("FAIL %s_first_frame got %b bad=%0d want %b bad=0", nm, fb, bad, {1'b1, 8'h67, 1'b0}); end
      capture_gap(1'b0, bad, busy_after);
      tick();
      tick();
      capture_frame(-1, -1, -1, fb, bad, cs_pos);
      $display("%s next frame byte %h", nm, fb[8:1]);
      checks++; if (fb !== {1'b1, 8'h73, 1'b0} || cs_pos !== FRAME_CYC - 1) begin errors++; $display("FAIL %s_next_frame got %b cs=%0d want %b cs=%0d", nm, fb, cs_pos, {1'b1, 8'h73, 1'b0}, FRAME_CYC - 1); end
      capture_gap(1'b0, bad, busy_after);
      capture_idle(60, act);
      checks++; if (act !== 0) begin errors++; $display("FAIL %s_no_third got %0d active cycles want 0", nm, act); end
   endtask

   task automatic test_last_gap();
      go_req = 1'b1;
      tick();
      go_req = 1'b0;
      tick();
      capture_frame(-1, -1, -1, fb, bad, cs_pos);
      capture_gap(1'b1, bad, busy_after);
      checks++; if (bad !== 0 || busy_after !== 1'b0) begin errors++; $display("FAIL lastgap_gap got bad=%0d busy_after=%b want 0 0", bad, busy_after); end
      tick();
      checks++; if (busy !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL lastgap_load got busy=%b tx=%b want 1 1", busy, tx); end
      tick();
      capture_frame(-1, -1, -1, fb, bad, cs_pos);
      $display("test_last_gap frame byte %h", fb[8:1]);
      checks++; if (fb !== {1'b1, 8'h67, 1'b0} || bad !== 0 || cs_pos !== FRAME_CYC - 1) begin errors++; $display("FAIL lastgap_frame got %b bad=%0d cs=%0d want %b 0 %0d", fb, bad, cs_pos, {1'b1, 8'h67, 1'b0}, FRAME_CYC - 1); end
      capture_gap(1'b0, bad, busy_after);
   endtask

   task automatic test_reset_mid();
      go_req = 1'b1;
      tick();
      go_req = 1'b0;
      tick();
      // Middle of data bit 4 of 0x67, which is a 0.
      repeat (5 * BAUD_DIV + BAUD_DIV / 2) tick();
      checks++; if (tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_before got tx=%b busy=%b want 0 1", tx, busy); end
      rst_n = 1'b0;
      #1;
      checks++; if (tx !== 1'b1 || busy !== 1'b0 || cmd_sent !== 1'b0) begin errors++; $display("FAIL rstmid_async got tx=%b busy=%b cmd_sent=%b want 1 0 0", tx, busy, cmd_sent); end
      checks++; if (last_cmd !== 8'h00 || go_active !== 1'b0) begin errors++; $display("FAIL rstmid_status got last_cmd=%h go_active=%b want 00 0", last_cmd, go_active); end
      repeat (3) tick();
      rst_n = 1'b1;
      capture_idle(200, act);
      checks++; if (act !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", act); end
      go_req = 1'b1;
      tick();
      go_req = 1'b0;
      tick();
      capture_frame(-1, -1, -1, fb, bad, cs_pos);
      $display("test_reset_mid recovery frame byte %h", fb[8:1]);
      checks++; if (fb !== {1'b1, 8'h67, 1'b0} || bad !== 0 || cs_pos !== FRAME_CYC - 1) begin errors++; $display("FAIL rstmid_recover got %b bad=%0d cs=%0d want %b 0 %0d", fb, bad, cs_pos, {1'b1, 8'h67, 1'b0}, FRAME_CYC - 1); end
      capture_gap(1'b0, bad, busy_after);
   endtask

   // Entered 33 cycles after the cmd_sent of a go frame, with go_active=1.
   task automatic test_heartbeat();
`ifdef AUTH_HEARTBEAT_EN
      for (int r = 0; r < 2; r++) begin
         capture_idle(HB_PERIOD - GAP_CYC - 1, act);
         checks++; if (act !== 0) begin errors++; $display("FAIL hb_wait%0d got %0d active cycles want 0", r, act); end
         tick();
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hb_load%0d got busy=%b want 1", r, busy); end
         tick();
         capture_frame(-1, -1, -1, fb, bad, cs_pos);
         $display("test_heartbeat repeat %0d byte %h", r, fb[8:1]);
         checks++; if (fb !== {1'b1, 8'h67, 1'b0} || bad !== 0 || cs_pos !== FRAME_CYC - 1) begin errors++; $display("FAIL hb_frame%0d got %b bad=%0d cs=%0d want %b 0 %0d", r, fb, bad, cs_pos, {1'b1, 8'h67, 1'b0}, FRAME_CYC - 1); end
         capture_gap(1'b0, bad, busy_after);
      end
`else
      capture_idle(10000, act);
      checks++; if (act !== 0) begin errors++; $display("FAIL nohb_quiet got %0d active cycles want 0", act); end
`endif
      stop_req = 1'b1;
      tick();
      stop_req = 1'b0;
      tick();
      capture_frame(-1, -1, -1, fb, bad, cs_pos);
      $display("test_heartbeat stop frame byte %h", fb[8:1]);
      checks++; if (fb !== {1'b1, 8'h73, 1'b0} || bad !== 0) begin errors++; $display("FAIL hb_stop_frame got %b bad=%0d want %b 0", fb, bad, {1'b1, 8'h73, 1'b0}); end
      capture_gap(1'b0, bad, busy_after);
      checks++; if (go_active !== 1'b0) begin errors++; $display("FAIL hb_stop_go_active got %b want 0", go_active); end
      capture_idle(10000, act);
      checks++; if (act !== 0) begin errors++; $display("FAIL hb_halted got %0d active cycles want 0", act); end
   endtask

   initial begin
      test_reset();
      test_go();
      test_both();
      test_stop_mid();
      test_queue(30, 60, 100, "go_go_stop");
      test_queue(90, -1, 30, "stop_sticky");
      test_last_gap();
      test_reset_mid();
      test_heartbeat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_auth_cmd_tx
